lpf_st_sink: RTL and testbench
==============================

# lpf_st_sink

Avalon-ST sink that consumes the filtered sample stream from the FIR low-pass output. It applies real backpressure, drops error-flagged beats, and converts each signed IN_W-bit result to a signed OUT_W-bit sample by round-half-up plus saturation. Samples are buffered in a FIFO for a downstream reader. It sits between the FIR source port and any consumer, such as a DAC driver or capture logic.

## Interface
- IN_W, 21: filter output width, signed two's complement.
- OUT_W, 8: stored sample width, signed.
- SHIFT, 11: right-shift applied before saturation; must satisfy 1 ≤ SHIFT < IN_W.
- DEPTH, 16: FIFO depth; power of two, ≥ 4.

- sclk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ast_sink_data  in  IN_W  filtered sample.
- ast_sink_valid  in  1  beat valid.
- ast_sink_error  in  2  nonzero marks the beat bad.
- ast_sink_ready  out  1  sink can accept; registered; readyLatency 0.
- rd_en  in  1  pop request.
- rd_data  out  OUT_W  popped sample.
- rd_valid  out  1  one-cycle strobe; rd_data is valid.
- empty  out  1  FIFO holds no samples.
- level  out  log2(DEPTH)+1  samples stored.
- err_cnt  out  16  dropped error beats; saturates at 0xFFFF.
- sat_cnt  out  16  samples clipped; saturates at 0xFFFF.

## Operation
- **Accept:** a beat is accepted on an edge where ast_sink_valid && ast_sink_ready are both high. With valid high and ready low, nothing happens; the source holds the beat.
- **Stage 1 register:** captures the accepted beat (s1_valid, s1_data, s1_err).
- **Stage 2, error path:** if s1_err is nonzero, the beat is discarded, nothing is written, and err_cnt increments.
- **Stage 2, good path:**
  - Sign-extend s1_data to IN_W+1 bits.
  - Add 2^(SHIFT-1).
  - Arithmetic shift right by SHIFT.
  - Clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Write the result into the FIFO.
  - If a clamp occurred, increment sat_cnt.
- **Reservation count:** reserved = level + s1_valid.
  - ast_sink_ready is registered as (reserved_next < DEPTH).
  - This guarantees no overflow even with a beat in flight.
  - Ready may therefore deassert one sample early; this is intended.
- **Read:** rd_en while !empty pops the head. rd_data is registered, and rd_valid is high for one cycle. rd_en while empty is ignored: rd_valid stays 0 and no pointer moves.
- **Simultaneous push and pop:** level is unchanged, both pointers advance, and no data is lost.
- **Pointer wrap:** pointers are log2(DEPTH) bits and wrap naturally. level distinguishes full from empty.
- **Counters:** both counters hold at 0xFFFF and never wrap.
- **Reset:** asserting rst_n at any time, including mid-stream, immediately clears:
  - pointers, level, s1_valid, rd_valid, rd_data, err_cnt and sat_cnt all go to 0;
  - empty goes to 1;
  - ast_sink_ready goes to 0.
  
  Any in-flight beat is lost.

## Timing
- **Reset values:**
  - ast_sink_ready=0, rd_valid=0, rd_data=0.
  - empty=1, level=0.
  - err_cnt=0, sat_cnt=0.
- **Ready after reset:** ast_sink_ready rises on the first sclk edge after rst_n deasserts.
- **Ingress latency:** beat accepted at edge T, captured in stage 1 at T, written at edge T+1. level and empty reflect the write after T+1.
- **Read latency:** rd_en sampled at edge R gives rd_data and rd_valid valid during the cycle after R. level decrements after R.
- **Minimum write-to-read:** accept at T, rd_en sampled at T+2, data visible after T+2.
- **Throughput:** one sample per cycle sustained in and out when the FIFO is neither full nor empty.
- **Full condition:** when reserved reaches DEPTH, ast_sink_ready is low starting the next cycle. It returns high the cycle after the pop that frees a slot.

## Test plan
- **Reset behaviour:** hold rst_n=0 for 5 cycles, then release. ready=0 during reset and is 1 one cycle after release. empty=1, level=0, both counters 0.
- **Rounding, defaults:** feed 0x000400, 0x0003FF, 0x1FFC00, 0x1FFBFF, then pop 4. Required rd_data sequence: 0x01, 0x00, 0x00, 0xFF, with sat_cnt=0.
- **Saturation:** feed 0x0FFFFF and 0x100000. Required rd_data: 0x7F then 0x80, and sat_cnt=2.
- **Error drop:** feed 3 beats with error 0,2,0 and data 0x000800, 0x001000, 0x001800. Required: level=2, rd_data 0x01 then 0x03, err_cnt=1.
- **Full and backpressure:** hold valid=1 with rd_en=0 for 40 cycles.
  - Exactly 16 beats are accepted and ready stays low thereafter.
  - One pop re-raises ready and exactly one more beat is accepted.
  - All 16 original beats drain in order.
- **Concurrent traffic and reset:** run valid=1 and rd_en=1 continuously for 100 cycles with incrementing data. Then assert rst_n mid-stream.
  - Before reset: level stays constant, output matches input order, there are no gaps after fill, and pointers wrap at least 5 times.
  - Reset clears all state within the same cycle.

Source files
------------

// File: rtl/lpf_st_sink_if.sv
// Purpose : bundle of the Avalon-ST sink handshake and the FIFO read/status
//           signals of lpf_st_sink.
// Modports:
//   master - the side that sources filter beats and pops samples
//            (drives data/valid/error and rd_en).
//   slave  - the lpf_st_sink itself (drives ready, read data and status).
interface lpf_st_sink_if #(
    parameter int IN_W  = 21,
    parameter int OUT_W = 8,
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [IN_W-1:0]  ast_sink_data;
    logic             ast_sink_valid;
    logic [1:0]       ast_sink_error;
    logic             ast_sink_ready;
    logic             rd_en;
    logic [OUT_W-1:0] rd_data;
    logic             rd_valid;
    logic             empty;
    logic [LW-1:0]    level;
    logic [15:0]      err_cnt;
    logic [15:0]      sat_cnt;

    modport master (
        output ast_sink_data, ast_sink_valid, ast_sink_error, rd_en,
        input  ast_sink_ready, rd_data, rd_valid, empty, level, err_cnt, sat_cnt
    );

    modport slave (
        input  ast_sink_data, ast_sink_valid, ast_sink_error, rd_en,
        output ast_sink_ready, rd_data, rd_valid, empty, level, err_cnt, sat_cnt
    );
endinterface

// File: rtl/lpf_st_sink.sv
// Purpose : Avalon-ST sink for the FIR low-pass output. Accepts beats with
//           registered backpressure, drops error-flagged beats, rounds
//           (half-up) and saturates each IN_W-bit result down to OUT_W bits
//           and buffers the samples in a DEPTH-entry FIFO.
// Ports   :
//   sclk  - sole clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - lpf_st_sink_if.slave: sink handshake (data/valid/error/ready),
//           pop interface (rd_en/rd_data/rd_valid), status (empty/level),
//           saturating drop and clip counters (err_cnt/sat_cnt)
module lpf_st_sink #(
    parameter int IN_W  = 21,
    parameter int OUT_W = 8,
    parameter int SHIFT = 11,
    parameter int DEPTH = 16
) (
    input  logic        sclk,
    input  logic        rst_n,
    lpf_st_sink_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic signed [IN_W:0] SAT_MAX = (IN_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [IN_W:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [IN_W:0] RND     = (IN_W+1)'(1) << (SHIFT-1);

    logic             r_s1_valid;
    logic [IN_W-1:0]  r_s1_data;
    logic [1:0]       r_s1_err;
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             r_ready;
    logic             r_rd_valid;
    logic [OUT_W-1:0] r_rd_data;
    logic [15:0]      r_err_cnt;
    logic [15:0]      r_sat_cnt;
    logic [OUT_W-1:0] r_mem [DEPTH];

    logic               w_accept;
    logic               w_push;
    logic               w_drop;
    logic               w_pop;
    logic signed [IN_W:0] w_ext;
    logic signed [IN_W:0] w_sum;
    logic signed [IN_W:0] w_shr;
    logic               w_clip_hi;
    logic               w_clip_lo;
    logic [OUT_W-1:0]   w_q;
    logic [LW-1:0]      w_level_nxt;
    logic [LW:0]        w_reserved_nxt;

    assign w_accept = bus.ast_sink_valid & r_ready;
    assign w_push   = r_s1_valid & (r_s1_err == 2'b00);
    assign w_drop   = r_s1_valid & (r_s1_err != 2'b00);
    assign w_pop    = bus.rd_en & (r_level != '0);

    // One guard bit keeps the rounding add from overflowing at full scale.
    assign w_ext     = {r_s1_data[IN_W-1], r_s1_data};
    assign w_sum     = w_ext + RND;
    assign w_shr     = w_sum >>> SHIFT;
    assign w_clip_hi = (w_shr > SAT_MAX);
    assign w_clip_lo = (w_shr < SAT_MIN);
    assign w_q       = w_clip_hi ? SAT_MAX[OUT_W-1:0] :
                       w_clip_lo ? SAT_MIN[OUT_W-1:0] : w_shr[OUT_W-1:0];

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + LW'(1);
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - LW'(1);
        end
    end

    // A beat sitting in stage 1 already owns a FIFO slot, so count it when
    // deciding ready; this can drop ready one sample early but never overflows.
    assign w_reserved_nxt = {1'b0, w_level_nxt} + {{LW{1'b0}}, w_accept};

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_err   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_ready    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_err_cnt  <= '0;
            r_sat_cnt  <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_data <= bus.ast_sink_data;
                r_s1_err  <= bus.ast_sink_error;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + PW'(1);
                r_rd_data <= r_mem[r_rd_ptr];
            end
            r_rd_valid <= w_pop;
            r_level    <= w_level_nxt;
            r_ready    <= (w_reserved_nxt < (LW+1)'(DEPTH));
            if (w_drop && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
            if (w_push && (w_clip_hi || w_clip_lo) && (r_sat_cnt != 16'hFFFF)) begin
                r_sat_cnt <= r_sat_cnt + 16'd1;
            end
        end
    end

    // Sample storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge sclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_q;
        end
    end

    assign bus.ast_sink_ready = r_ready;
    assign bus.rd_data        = r_rd_data;
    assign bus.rd_valid       = r_rd_valid;
    assign bus.empty          = (r_level == '0);
    assign bus.level          = r_level;
    assign bus.err_cnt        = r_err_cnt;
    assign bus.sat_cnt        = r_sat_cnt;
endmodule

// File: tb/tb_lpf_st_sink.sv
`timescale 1ns/1ps
module tb_lpf_st_sink;
    localparam int IN_W  = 21;
    localparam int OUT_W = 8;
    localparam int SHIFT = 11;
    localparam int DEPTH = 16;
    localparam int MAXV  = 127;
    localparam int MINV  = -128;

    logic sclk  = 1'b0;
    logic rst_n = 1'b1;

    lpf_st_sink_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus ();

    lpf_st_sink #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
        .sclk  (sclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 sclk = ~sclk;

    int n_checks = 0;
    int n_fail   = 0;
    int popped[$];

    function automatic void check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endfunction

    // Rounded, unclamped value: floor((x + 2^(SHIFT-1)) / 2^SHIFT).
    function automatic int round_sample(input logic [IN_W-1:0] d);
        int v;
        v = {{(32-IN_W){d[IN_W-1]}}, d};
        return (v + (1 << (SHIFT-1))) >>> SHIFT;
    endfunction

    // ---------------- reference model ----------------
    bit               m_ready;
    bit               m_s1_valid;
    logic [IN_W-1:0]  m_s1_data;
    logic [1:0]       m_s1_err;
    bit               m_rd_valid;
    int               m_rd_q;
    int               m_err;
    int               m_sat;
    int               m_fifo[$];

    always @(posedge sclk or negedge rst_n) begin
        bit acc;
        bit pop;
        int q;
        if (!rst_n) begin
            m_ready    = 1'b0;
            m_s1_valid = 1'b0;
            m_rd_valid = 1'b0;
            m_rd_q     = 0;
            m_err      = 0;
            m_sat      = 0;
            m_fifo.delete();
        end else begin
            acc = bus.ast_sink_valid && m_ready;
            pop = bus.rd_en && (m_fifo.size() > 0);
            m_rd_valid = pop;
            if (pop) m_rd_q = m_fifo.pop_front();
            if (m_s1_valid) begin
                if (m_s1_err != 2'b00) begin
                    if (m_err < 65535) m_err++;
                end else begin
                    q = round_sample(m_s1_data);
                    if (q > MAXV || q < MINV) begin
                        if (m_sat < 65535) m_sat++;
                        q = (q > MAXV) ? MAXV : MINV;
                    end
                    m_fifo.push_back(q);
                end
            end
            m_s1_valid = acc;
            if (acc) begin
                m_s1_data = bus.ast_sink_data;
                m_s1_err  = bus.ast_sink_error;
            end
            m_ready = (m_fifo.size() + int'(m_s1_valid)) < DEPTH;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge sclk) begin
        logic [7:0] exp_d;
        exp_d = m_rd_q[7:0];
        check("ready",    longint'(bus.ast_sink_ready), longint'(m_ready));
        check("level",    longint'(bus.level),          longint'(m_fifo.size()));
        check("empty",    longint'(bus.empty),          longint'(m_fifo.size() == 0));
        check("rd_valid", longint'(bus.rd_valid),       longint'(m_rd_valid));
        if (m_rd_valid || !rst_n)
            check("rd_data", longint'(bus.rd_data), longint'(exp_d));
        check("err_cnt",  longint'(bus.err_cnt),        longint'(m_err));
        check("sat_cnt",  longint'(bus.sat_cnt),        longint'(m_sat));
        if (bus.rd_valid) popped.push_back(int'(signed'(bus.rd_data)));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(output bit took);
        took = bus.ast_sink_valid && bus.ast_sink_ready;
        @(posedge sclk);
        #1;
    endtask

    task automatic idle(input int n);
        bit t;
        repeat (n) tick(t);
    endtask

    task automatic send(input logic [IN_W-1:0] d, input logic [1:0] e);
        bit took;
        took = 1'b0;
        bus.ast_sink_valid = 1'b1;
        bus.ast_sink_data  = d;
        bus.ast_sink_error = e;
        for (int i = 0; i < 50 && !took; i++) tick(took);
        if (!took) check("send_timeout", 0, 1);
    endtask

    task automatic pop_n(input int n);
        bus.rd_en = 1'b1;
        idle(n);
        bus.rd_en = 1'b0;
        idle(2);
    endtask

    initial begin
        bit took;
        int k, acc, extra, lmin, lmax, gaps, bad;
        bus.ast_sink_valid = 1'b0;
        bus.ast_sink_data  = '0;
        bus.ast_sink_error = '0;
        bus.rd_en          = 1'b0;

        // reset behaviour
        #1 rst_n = 1'b0;
        repeat (5) @(posedge sclk);
        #1;
        check("rst_ready",   longint'(bus.ast_sink_ready), 0);
        check("rst_empty",   longint'(bus.empty), 1);
        check("rst_level",   longint'(bus.level), 0);
        check("rst_err_cnt", longint'(bus.err_cnt), 0);
        check("rst_sat_cnt", longint'(bus.sat_cnt), 0);
        rst_n = 1'b1;
        check("ready_before_edge", longint'(bus.ast_sink_ready), 0);
        idle(1);
        check("ready_after_release", longint'(bus.ast_sink_ready), 1);

        // rounding
        popped.delete();
        send(21'h000400, 2'd0);
        send(21'h0003FF, 2'd0);
        send(21'h1FFC00, 2'd0);
        send(21'h1FFBFF, 2'd0);
        bus.ast_sink_valid = 1'b0;
        idle(2);
        pop_n(4);
        check("round_count", popped.size(), 4);
        check("round_0", popped[0], 1);
        check("round_1", popped[1], 0);
        check("round_2", popped[2], 0);
        check("round_3", popped[3], -1);
        check("round_sat_cnt", longint'(bus.sat_cnt), 0);

        // saturation
        popped.delete();
        send(21'h0FFFFF, 2'd0);
        send(21'h100000, 2'd0);
        bus.ast_sink_valid = 1'b0;
        idle(2);
        pop_n(2);
        check("sat_0", popped[0], 127);
        check("sat_1", popped[1], -128);
        check("sat_cnt", longint'(bus.sat_cnt), 2);

        // error drop
        popped.delete();
        send(21'h000800, 2'd0);
        send(21'h001000, 2'd2);
        send(21'h001800, 2'd0);
        bus.ast_sink_valid = 1'b0;
        idle(3);
        check("err_level", longint'(bus.level), 2);
        check("err_cnt",   longint'(bus.err_cnt), 1);
        pop_n(2);
        check("err_pop_0", popped[0], 1);
        check("err_pop_1", popped[1], 3);

        // full and backpressure
        popped.delete();
        k = 0;
        bus.ast_sink_valid = 1'b1;
        bus.ast_sink_error = 2'd0;
        bus.ast_sink_data  = '0;
        for (int c = 0; c < 40; c++) begin
            tick(took);
            if (took) begin k++; bus.ast_sink_data = IN_W'(k << 11); end
        end
        acc = k;
        check("full_accepted", acc, 16);
        check("full_ready_low", longint'(bus.ast_sink_ready), 0);
        check("full_level", longint'(bus.level), 16);
        bus.rd_en = 1'b1;
        tick(took);
        if (took) begin k++; bus.ast_sink_data = IN_W'(k << 11); end
        bus.rd_en = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick(took);
            if (took) begin k++; bus.ast_sink_data = IN_W'(k << 11); end
        end
        extra = k - acc;
        check("full_extra_accept", extra, 1);
        bus.ast_sink_valid = 1'b0;
        idle(2);
        pop_n(20);
        check("drain_count", popped.size(), 17);
        bad = 0;
        for (int i = 0; i < popped.size(); i++) if (popped[i] != i) bad++;
        check("drain_order_errors", bad, 0);

        // concurrent traffic then mid-stream reset
        popped.delete();
        k = 0;
        lmin = 1000; lmax = -1; gaps = 0;
        bus.ast_sink_data  = '0;
        bus.ast_sink_valid = 1'b1;
        bus.rd_en          = 1'b1;
        for (int c = 0; c < 100; c++) begin
            tick(took);
            if (took) begin k++; bus.ast_sink_data = IN_W'((k % 64) << 11); end
            if (c >= 5) begin
                if (int'(bus.level) < lmin) lmin = int'(bus.level);
                if (int'(bus.level) > lmax) lmax = int'(bus.level);
                if (!bus.rd_valid) gaps++;
            end
        end
        check("conc_level_const", lmax - lmin, 0);
        check("conc_gaps", gaps, 0);
        check("conc_wraps", longint'(popped.size() >= 5 * DEPTH), 1);
        bad = 0;
        for (int i = 0; i < popped.size(); i++) if (popped[i] != (i % 64)) bad++;
        check("conc_order_errors", bad, 0);
        check("pre_rst_err_cnt", longint'(bus.err_cnt), 1);
        check("pre_rst_sat_cnt", longint'(bus.sat_cnt), 2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready",    longint'(bus.ast_sink_ready), 0);
        check("mid_rst_level",    longint'(bus.level), 0);
        check("mid_rst_empty",    longint'(bus.empty), 1);
        check("mid_rst_rd_valid", longint'(bus.rd_valid), 0);
        check("mid_rst_rd_data",  longint'(bus.rd_data), 0);
        check("mid_rst_err_cnt",  longint'(bus.err_cnt), 0);
        check("mid_rst_sat_cnt",  longint'(bus.sat_cnt), 0);
        bus.ast_sink_valid = 1'b0;
        bus.rd_en          = 1'b0;
        @(posedge sclk);
        #1 rst_n = 1'b1;
        idle(2);

        // randomized traffic against the model
        for (int c = 0; c < 1200; c++) begin
            bus.rd_en = (c < 600) ? ($urandom % 3 != 0) : ($urandom % 4 == 0);
            tick(took);
            if (took || !bus.ast_sink_valid) begin
                bus.ast_sink_valid = ($urandom % 4 != 0);
                bus.ast_sink_data  = IN_W'($urandom);
                bus.ast_sink_error = ($urandom % 5 == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            end
        end
        bus.ast_sink_valid = 1'b0;
        bus.rd_en = 1'b1;
        idle(DEPTH + 4);
        bus.rd_en = 1'b0;
        idle(2);
        check("final_empty", longint'(bus.empty), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
